mig_seq_eval: RTL and testbench
===============================

MIG_SEQ_EVAL -- requirements
Module: mig_seq_eval

Interface
REQ-001 The block SHALL expose parameter N_IN, default 7, as the number of primary inputs.
REQ-002 The block SHALL expose parameter N_NODES, default 8, as the number of majority nodes.
REQ-003 The block SHALL expose derived localparam SIG_W = clog2(1+N_IN+N_NODES) as the signal-index width; index 0 = constant 0, 1..N_IN = x[0..N_IN-1], N_IN+1.. = node 0..N_NODES-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port cfg_we, input, 1 bit: node-config write strobe.
REQ-007 The block SHALL have port cfg_addr, input, clog2(N_NODES) bits: the node written.
REQ-008 The block SHALL have port cfg_data, input, 3*(SIG_W+1) bits: {inv_a,idx_a,inv_b,idx_b,inv_c,idx_c}.
REQ-009 The block SHALL have port out_sel, input, SIG_W+1 bits: {inv,idx} of the output signal, sampled at job start.
REQ-010 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_x (input, N_IN): the single-vector request.
REQ-011 The block SHALL have port sweep_start, input, 1 bit: start an exhaustive enumeration of all 2^N_IN vectors.
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 1) and out_last (output, 1): the result stream.
REQ-013 The block SHALL have port cfg_err, output, 1 bit: sticky flag, set on a write rejected while busy.

Function
REQ-014 Each node SHALL compute MAJ(a^inv_a, b^inv_b, c^inv_c), where a, b and c are the signals selected by idx_a, idx_b and idx_c.
REQ-015 The FSM SHALL have states IDLE, EVAL and OUT; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, in_valid SHALL latch in_x, clear all node registers and enter EVAL with node counter k=0.
REQ-017 In EVAL, node k SHALL be evaluated and registered in cycle k; after k=N_NODES-1 the FSM SHALL enter OUT.
REQ-018 out_valid SHALL assert exactly N_NODES+1 cycles after the in_valid&in_ready cycle.
REQ-019 A node index of k or higher SHALL read the cleared value 0; an index outside the range SHALL read 0.
REQ-020 In OUT, out_data SHALL be the selected signal XOR inv and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 out_valid&out_ready SHALL return the FSM to IDLE, or, in sweep mode, to EVAL with vector+1.
REQ-022 sweep_start in IDLE SHALL start the vector at 0 and SHALL take priority over a simultaneous in_valid; sweep_start is ignored outside IDLE.
REQ-023 out_last SHALL be 1 only with the result for vector 2^N_IN-1 in sweep mode, and SHALL be 1 for every single-vector result.
REQ-024 cfg_we in IDLE SHALL write the node config; cfg_we in EVAL or OUT SHALL be dropped and SHALL set cfg_err.
REQ-025 The sweep vector counter SHALL be N_IN+1 bits wide, so that it does not wrap before out_last.

Reset
REQ-026 rst SHALL force IDLE, in_ready=1, out_valid=0, out_data=0, out_last=0, cfg_err=0, k=0, the vector register to 0 and every node config to all-zero (constant-0 inputs).
REQ-027 rst asserted mid-EVAL or mid-OUT SHALL abort the job with no output produced; the next job after reset SHALL be evaluated from clean state.

Structure
REQ-028 Package mig_pkg SHALL hold the state enum, the node-config struct, the signal-index width function and the default parameters.
REQ-029 The three-input inverted majority SHALL be a sub-module mig_maj3, combinational, instanced once and time-shared across nodes.

Verification
REQ-030 The bench SHALL cover: node0=MAJ(x0,x2,x5), out_sel=node0, in_x=7'b0100101 -> out_data=1, out_last=1, out_valid at accept+9.
REQ-031 The bench SHALL cover: node0=MAJ(~const0,x0,x1) (OR), in_x=0 -> 0; in_x=7'b0000010 -> 1.
REQ-032 The bench SHALL cover: node0=MAJ(const0,x0,x1) (AND), sweep_start -> 128 results, exactly 32 ones, out_last only on the 128th.
REQ-033 The bench SHALL cover: out_ready held 0 for 5 cycles in OUT -> out_data and out_valid stable, in_ready=0, no extra results.
REQ-034 The bench SHALL cover: cfg_we during EVAL -> config unchanged and cfg_err=1 until rst.
REQ-035 The bench SHALL cover: rst at k=3 -> all outputs at reset values next cycle; the following request gives the correct result.

Source files
------------

// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared types, defaults and width helper for the sequential MIG evaluator
// Contents:
//   N_IN_DEF, N_NODES_DEF : default number of primary inputs and majority nodes
//   IDX_MAX_W             : storage width of a signal index inside a node config
//   state_t               : evaluator FSM states
//   sig_ref_t, node_cfg_t : one {inv,idx} operand, and the three operands of a node
//   sig_width()           : signal-index width for a given input/node count
package mig_pkg;

    localparam int N_IN_DEF    = 7;
    localparam int N_NODES_DEF = 8;
    localparam int IDX_MAX_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 inv;
        logic [IDX_MAX_W-1:0] idx;
    } sig_ref_t;

    typedef struct packed {
        sig_ref_t a;
        sig_ref_t b;
        sig_ref_t c;
    } node_cfg_t;

    // Signal space is constant 0, then the primary inputs, then the nodes.
    function automatic int sig_width(input int n_in, input int n_nodes);
        return $clog2(1 + n_in + n_nodes);
    endfunction

endpackage

// File: rtl/mig_maj3.sv
// rtl/mig_maj3.sv - combinational three-input majority with per-input inversion
// Ports:
//   a, b, c             : operand values
//   inv_a, inv_b, inv_c : invert the matching operand before voting
//   y                   : MAJ(a^inv_a, b^inv_b, c^inv_c)
module mig_maj3 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic inv_a,
    input  logic inv_b,
    input  logic inv_c,
    output logic y
);

    logic aa;
    logic bb;
    logic cc;

    assign aa = a ^ inv_a;
    assign bb = b ^ inv_b;
    assign cc = c ^ inv_c;
    assign y  = (aa & bb) | (aa & cc) | (bb & cc);

endmodule

// File: rtl/mig_seq_eval.sv
// rtl/mig_seq_eval.sv - sequential majority-inverter-graph evaluator, one node per cycle
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_data  : node config write {inv_a,idx_a,inv_b,idx_b,inv_c,idx_c}, IDLE only
//   out_sel                   : {inv,idx} of the result signal, captured at job start
//   in_valid/in_ready/in_x    : single-vector request
//   sweep_start               : enumerate all 2^N_IN vectors
//   out_valid/out_ready/out_data/out_last : result stream
//   cfg_err                   : sticky, set when a config write arrives while busy
module mig_seq_eval
    import mig_pkg::*;
#(
    parameter int  N_IN    = N_IN_DEF,
    parameter int  N_NODES = N_NODES_DEF,
    localparam int SIG_W   = sig_width(N_IN, N_NODES),
    localparam int ADDR_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [3*(SIG_W+1)-1:0] cfg_data,
    input  logic [SIG_W:0]         out_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_x,
    input  logic                   sweep_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_data,
    output logic                   out_last,
    output logic                   cfg_err
);

    localparam int RW    = SIG_W + 1;
    localparam int N_SIG = 1 + N_IN + N_NODES;
    localparam int K_W   = ADDR_W;
    localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [N_IN:0]    vec_q, vec_d;
    logic             sweep_q, sweep_d;
    logic [SIG_W:0]   sel_q, sel_d;
    logic [N_NODES-1:0] node_q, node_d;
    logic             cfg_err_q, cfg_err_d;
    node_cfg_t        cfg_q [N_NODES];
    node_cfg_t        cfg_d [N_NODES];

    logic [N_SIG-1:0] sig_vec;
    node_cfg_t        cur_cfg;
    logic             op_a, op_b, op_c, maj_y;
    logic             sel_val;

    function automatic sig_ref_t to_ref(input logic [RW-1:0] r);
        sig_ref_t s;
        s.inv = r[RW-1];
        s.idx = IDX_MAX_W'(r[SIG_W-1:0]);
        return s;
    endfunction

    // Indices past the end of the signal space read as constant 0.
    function automatic logic pick(input logic [IDX_MAX_W-1:0] idx, input logic [N_SIG-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_SIG; i++) begin
            if (int'(idx) == i) begin
                r = v[i];
            end
        end
        return r;
    endfunction

    // Node registers are cleared at every job start, so a node at or past k
    // naturally reads 0 while it has not been evaluated yet.
    assign sig_vec = {node_q, vec_q[N_IN-1:0], 1'b0};
    assign cur_cfg = cfg_q[k_q];
    assign op_a    = pick(cur_cfg.a.idx, sig_vec);
    assign op_b    = pick(cur_cfg.b.idx, sig_vec);
    assign op_c    = pick(cur_cfg.c.idx, sig_vec);
    assign sel_val = pick(IDX_MAX_W'(sel_q[SIG_W-1:0]), sig_vec) ^ sel_q[SIG_W];

    mig_maj3 u_maj3 (
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .inv_a (cur_cfg.a.inv),
        .inv_b (cur_cfg.b.inv),
        .inv_c (cur_cfg.c.inv),
        .y     (maj_y)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        vec_d     = vec_q;
        sweep_d   = sweep_q;
        sel_d     = sel_q;
        node_d    = node_q;
        cfg_err_d = cfg_err_q;
        cfg_d     = cfg_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (cfg_we && (int'(cfg_addr) < N_NODES)) begin
                    cfg_d[cfg_addr].a = to_ref(cfg_data[3*RW-1 -: RW]);
                    cfg_d[cfg_addr].b = to_ref(cfg_data[2*RW-1 -: RW]);
                    cfg_d[cfg_addr].c = to_ref(cfg_data[RW-1 -: RW]);
                end
                if (sweep_start) begin
                    sweep_d = 1'b1;
                    vec_d   = '0;
                    sel_d   = out_sel;
                    node_d  = '0;
                    k_d     = '0;
                    state_d = ST_EVAL;
                end else if (in_valid) begin
                    sweep_d = 1'b0;
                    vec_d   = {1'b0, in_x};
                    sel_d   = out_sel;
                    node_d  = '0;
                    k_d     = '0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                cfg_err_d = cfg_err_q | cfg_we;
                node_d[k_q] = maj_y;
                if (k_q == K_W'(N_NODES - 1)) begin
                    k_d     = '0;
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_OUT: begin
                cfg_err_d = cfg_err_q | cfg_we;
                out_valid = 1'b1;
                out_data  = sel_val;
                out_last  = !sweep_q || (vec_q == LAST_VEC);
                if (out_ready) begin
                    if (sweep_q && (vec_q != LAST_VEC)) begin
                        vec_d   = vec_q + (N_IN+1)'(1);
                        node_d  = '0;
                        k_d     = '0;
                        state_d = ST_EVAL;
                    end else begin
                        sweep_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            vec_q     <= '0;
            sweep_q   <= 1'b0;
            sel_q     <= '0;
            node_q    <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < N_NODES; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            vec_q     <= vec_d;
            sweep_q   <= sweep_d;
            sel_q     <= sel_d;
            node_q    <= node_d;
            cfg_err_q <= cfg_err_d;
            for (int i = 0; i < N_NODES; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mig_seq_eval.sv
// tb/tb_mig_seq_eval.sv - directed self-checking bench for mig_seq_eval
module tb_mig_seq_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic [4:0]  out_sel;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_x;
    logic        sweep_start;
    logic        out_valid;
    logic        out_ready;
    logic        out_data;
    logic        out_last;
    logic        cfg_err;

    int n_total = 0;
    int n_bad   = 0;

    mig_seq_eval dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .out_sel     (out_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .sweep_start (sweep_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Signal indices: 0 = const0, 1+i = x[i], 8+j = node j.
    function automatic logic [14:0] mk(input logic ia, input logic [3:0] a,
                                       input logic ib, input logic [3:0] b,
                                       input logic ic, input logic [3:0] c);
        return {ia, a, ib, b, ic, c};
    endfunction

    task automatic write_cfg(input logic [2:0] addr, input logic [14:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [6:0] x, input logic [4:0] sel,
                           input logic exp_d);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_x     = x;
        out_sel  = sel;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_last"}, 32'(out_last), 32'd1);
        @(negedge clk);
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    task automatic count_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        int nres, ones, nlast, lastpos, mism, cyc;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_sel = '0;
        in_valid = 1'b0; in_x = '0; sweep_start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;

        // node0 = MAJ(x0,x2,x5)
        write_cfg(3'd0, mk(1'b0, 4'd1, 1'b0, 4'd3, 1'b0, 4'd6));
        run_one("maj_a", 7'b0100101, 5'd8, 1'b1);
        run_one("maj_b", 7'b0000001, 5'd8, 1'b0);
        run_one("maj_inv", 7'b0000001, 5'b11000, 1'b1);

        // node1 = MAJ(node0, x6, const0) = node0 & x6
        write_cfg(3'd1, mk(1'b0, 4'd8, 1'b0, 4'd7, 1'b0, 4'd0));
        run_one("chain_a", 7'b1100101, 5'd9, 1'b1);
        run_one("chain_b", 7'b0100101, 5'd9, 1'b0);

        // node2 = MAJ(~node5, x0, x1); node5 evaluates to 1 later in the job
        write_cfg(3'd5, mk(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd1));
        write_cfg(3'd2, mk(1'b1, 4'd13, 1'b0, 4'd1, 1'b0, 4'd2));
        run_one("fwd_a", 7'b0000001, 5'd10, 1'b1);
        run_one("fwd_b", 7'b0000001, 5'd10, 1'b1);

        // node0 = MAJ(~const0, x0, x1) = OR
        write_cfg(3'd0, mk(1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 4'd2));
        run_one("or_0", 7'b0000000, 5'd8, 1'b0);
        run_one("or_1", 7'b0000010, 5'd8, 1'b1);

        // Backpressure in OUT, with a stray sweep_start that must be ignored
        out_ready = 1'b0;
        @(negedge clk);
        in_x = 7'b0000010; out_sel = 5'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp", lat);
        check("bp_lat", 32'(lat), 32'd9);
        sweep_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sweep_start = 1'b0;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain", 32'(out_valid), 32'd0);
        count_valid("bp_extra", 12);
        check("bp_idle", 32'(in_ready), 32'd1);

        // Config write during EVAL is dropped and flagged
        @(negedge clk);
        in_x = 7'b0000010; out_sel = 5'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = mk(1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 4'd2);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_valid("cerr", lat);
        check("cerr_data", 32'(out_data), 32'd1);
        check("cerr_flag", 32'(cfg_err), 32'd1);
        @(negedge clk);
        run_one("cerr_keep", 7'b0000010, 5'd8, 1'b1);
        check("cerr_sticky", 32'(cfg_err), 32'd1);

        // Reset at k=3 aborts the job and clears config
        @(negedge clk);
        in_x = 7'b1111111; out_sel = 5'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        count_valid("abort_extra", 12);
        run_one("abort_clean", 7'b1111111, 5'd8, 1'b0);

        // node0 = MAJ(const0, x0, x1) = AND
        write_cfg(3'd0, mk(1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 4'd2));
        run_one("and_1", 7'b0000011, 5'd8, 1'b1);

        // Sweep, launched together with in_valid to exercise priority
        @(negedge clk);
        sweep_start = 1'b1; in_valid = 1'b1; in_x = 7'b0000011; out_sel = 5'd8;
        @(negedge clk);
        sweep_start = 1'b0; in_valid = 1'b0;
        nres = 0; ones = 0; nlast = 0; lastpos = -1; mism = 0; cyc = 0;
        while (nres < 128 && cyc < 3000) begin
            if (out_valid) begin
                if (out_data !== ((nres & 3) == 3)) mism++;
                if (out_data) ones++;
                if (out_last) begin
                    nlast++;
                    lastpos = nres;
                end
                nres++;
            end
            @(negedge clk);
            cyc++;
        end
        check("sweep_results", 32'(nres), 32'd128);
        check("sweep_ones", 32'(ones), 32'd32);
        check("sweep_mism", 32'(mism), 32'd0);
        check("sweep_nlast", 32'(nlast), 32'd1);
        check("sweep_lastpos", 32'(lastpos), 32'd127);
        count_valid("sweep_extra", 15);
        check("sweep_idle", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
